io_bridge: RTL and testbench
============================

IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter TX_DEPTH, default 8, is the UART TX FIFO depth; it SHALL be a power of two and at least 4.
REQ-002 Parameter FULL_MARGIN, default 2, is the number of free TX slots at which io_buffer_full asserts.
REQ-003 Port clk_in, input, 1: the single clock. All state SHALL update on its rising edge.
REQ-004 Port rst_in, input, 1: reset, synchronous and active-low.
REQ-005 Port rdy_in, input, 1: CPU-side accesses and the cycle counter SHALL freeze while low; the TX drain continues.
REQ-006 Port cpu_a, input, 32: CPU address bus.
REQ-007 Port cpu_dout, input, 8: CPU write data.
REQ-008 Port cpu_wr, input, 1: 1 = write, 0 = read.
REQ-009 Port io_din, output, 8: read data returned to the CPU.
REQ-010 Port io_sel_q, output, 1: high when io_din carries IO read data for this cycle.
REQ-011 Port io_buffer_full, output, 1: TX back-pressure to the CPU.
REQ-012 Port tx_data, output, 8: byte to the UART transmitter.
REQ-013 Port tx_valid, output, 1: tx_data is valid.
REQ-014 Port tx_ready, input, 1: the UART accepts the byte.
REQ-015 Port rx_data, input, 8: received UART byte.
REQ-016 Port rx_valid, input, 1: rx_data is valid.
REQ-017 Port rx_pop, output, 1: one-cycle pulse that consumes rx_data.
REQ-018 Port program_stop, output, 1: sticky; the program has ended and TX has drained.
REQ-019 Port tx_overflow, output, 1: sticky; a push was dropped because the FIFO was full.

Function
REQ-020 Decode: an access is an IO access iff cpu_a[17:16]==2'b11 and rdy_in is high; all other addresses SHALL be ignored.
REQ-021 Write to 0x30000:
- nonzero cpu_dout is pushed to the TX FIFO;
- 0x00 is ignored.
REQ-022 Write to 0x30004:
- pushes 0x00 to the TX FIFO;
- sets an internal stop_pending flag.
REQ-023 TX FIFO:
- circular buffer with pointer wrap at TX_DEPTH;
- count ranges 0..TX_DEPTH;
- push and pop in the same cycle leave count unchanged.
REQ-024 TX handshake:
- tx_valid = (count != 0);
- tx_data = head entry;
- a pop occurs when tx_valid and tx_ready are both high.
REQ-025 A push when count==TX_DEPTH, without a simultaneous pop, SHALL be dropped and set tx_overflow.
REQ-026 io_buffer_full SHALL be registered and equal (TX_DEPTH - next_count) <= FULL_MARGIN. This covers the one-cycle CPU write lag.
REQ-027 program_stop SHALL set on the first cycle where stop_pending is high and count==0 with no push pending. It SHALL remain set until reset.
REQ-028 Read of 0x30000:
- the next cycle io_din = rx_data if rx_valid, else 0x00;
- rx_pop pulses in the request cycle only if rx_valid.
REQ-029 Read of 0x30004..0x30007: the next cycle io_din = byte cpu_a[1:0] of a 32-bit snapshot, little-endian.
REQ-030 The snapshot SHALL load from the cycle counter on every read of 0x30004. Byte reads at 0x30005..0x30007 SHALL return the held snapshot.
REQ-031 Read latency SHALL be exactly 1 cycle. io_sel_q = (previous cycle was an IO read).
REQ-032 Reads of other IO addresses SHALL return 0x00.
REQ-033 Cycle counter:
- 32-bit;
- increments every cycle rdy_in is high after reset release;
- wraps from 0xFFFFFFFF to 0.

Reset
REQ-034 While rst_in==0, on each clock edge:
- FIFO pointers, count, counter and snapshot are cleared;
- stop_pending, program_stop and tx_overflow are cleared;
- io_din=0, io_sel_q=0, tx_valid=0, rx_pop=0, io_buffer_full=0.
REQ-035 A reset asserted mid-drain SHALL discard all FIFO contents; no byte is emitted after the reset edge.

Structure
REQ-036 IO address constants (0x30000, 0x30004) and the IO decode mask SHALL live in the shared define include.
REQ-037 The TX FIFO SHALL be a sub-module named io_tx_fifo, parameterised by depth. io_bridge SHALL contain decode, RX, counter and stop logic.

Verification
REQ-038 Write 'A' (0x41) to 0x30000 with tx_ready=1 -> tx_valid with tx_data=0x41 appears the next cycle and stays for exactly one cycle.
REQ-039 Write 0x00 to 0x30000 -> no push; count stays 0.
REQ-040 tx_ready=0, then 6 writes (TX_DEPTH=8) -> io_buffer_full=1 after the 6th.
REQ-041 tx_ready=0, then 9 writes -> tx_overflow=1; the first 8 bytes drain in order once tx_ready=1.
REQ-042 Reset release, then 100 cycles, then read 0x30004..0x30007 -> bytes 0x64,0,0,0 (±1 per the capture cycle), each returned one cycle after its request.
REQ-043 Write 'x', then write to 0x30004, with tx_ready=0 for 5 cycles -> program_stop rises only after bytes 0x78 and 0x00 are popped; a reset mid-drain clears both flags.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared IO map and address decode for the CPU-side IO bridge.
// Holds the register addresses, the IO window mask and the access classifier.
package io_bridge_pkg;

  localparam logic [31:0] IO_DECODE_MASK = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_DATA   = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_CYCLE  = 32'h0003_0004;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_CYCLE
  } io_sel_e;

  // SEL_CYCLE covers the whole 4-byte snapshot word at 0x30004..0x30007.
  function automatic io_sel_e io_decode(input logic [31:0] addr);
    if ((addr & IO_DECODE_MASK) != IO_DECODE_MASK) return SEL_NONE;
    if (addr == IO_ADDR_DATA) return SEL_DATA;
    if (addr[31:2] == IO_ADDR_CYCLE[31:2]) return SEL_CYCLE;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// UART TX byte FIFO: push lands next cycle, head shown combinationally while count != 0.
// Pushes into a full FIFO without a same-cycle pop are dropped and latch overflow.
module io_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int MARGIN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   next_count;
  logic          pop;
  logic          accept;

  assign valid  = (count != '0);
  assign data   = mem[rd_ptr];
  assign pop    = valid && ready;
  assign accept = push && ((count != CNT_MAX) || pop);

  always_comb begin
    next_count = count;
    if (accept && !pop)      next_count = count + CNT_ONE;
    else if (!accept && pop) next_count = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  // full looks at next_count so the CPU sees back-pressure one write early.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      count <= next_count;
      full  <= (DEPTH - int'(next_count)) <= MARGIN;
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/io_bridge.sv
// CPU IO bridge: UART TX/RX, cycle counter snapshot and program-stop detection.
// Reads return after exactly 1 cycle; TX back-pressure via registered io_buffer_full.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  io_din,
  output logic        io_sel_q,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop,
  output logic        tx_overflow
);

  io_sel_e     sel;
  logic        io_acc;
  logic        io_rd;
  logic        stop_wr;
  logic        push;
  logic [7:0]  push_data;
  logic [31:0] cycle_cnt;
  logic [31:0] snapshot;
  logic [31:0] snap_src;
  logic        stop_pending;

  assign io_acc    = rdy_in && ((cpu_a & IO_DECODE_MASK) == IO_DECODE_MASK);
  assign sel       = rdy_in ? io_decode(cpu_a) : SEL_NONE;
  assign io_rd     = io_acc && !cpu_wr;
  assign stop_wr   = cpu_wr && (sel == SEL_CYCLE) && (cpu_a == IO_ADDR_CYCLE);
  assign push      = stop_wr || (cpu_wr && (sel == SEL_DATA) && (cpu_dout != 8'h00));
  assign push_data = stop_wr ? 8'h00 : cpu_dout;
  assign rx_pop    = rst_in && io_rd && (sel == SEL_DATA) && rx_valid;

  // A read of the low byte returns the value being captured this very cycle.
  assign snap_src  = (cpu_a == IO_ADDR_CYCLE) ? cycle_cnt : snapshot;

  io_tx_fifo #(
    .DEPTH  (TX_DEPTH),
    .MARGIN (FULL_MARGIN)
  ) u_tx_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (push),
    .push_data (push_data),
    .ready     (tx_ready),
    .data      (tx_data),
    .valid     (tx_valid),
    .full      (io_buffer_full),
    .overflow  (tx_overflow)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cycle_cnt    <= '0;
      snapshot     <= '0;
      stop_pending <= 1'b0;
      program_stop <= 1'b0;
      io_din       <= 8'h00;
      io_sel_q     <= 1'b0;
    end else begin
      if (rdy_in) cycle_cnt <= cycle_cnt + 32'd1;
      io_sel_q <= io_rd;
      io_din   <= 8'h00;
      if (io_rd) begin
        case (sel)
          SEL_DATA:  io_din <= rx_valid ? rx_data : 8'h00;
          SEL_CYCLE: begin
            if (cpu_a == IO_ADDR_CYCLE) snapshot <= cycle_cnt;
            io_din <= 8'(snap_src >> {cpu_a[1:0], 3'b000});
          end
          default:   io_din <= 8'h00;
        endcase
      end
      if (stop_wr) stop_pending <= 1'b1;
      if (stop_pending && !tx_valid && !push) program_stop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// Directed plus random bench for io_bridge against a queue-based reference model.
module tb_io_bridge;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  io_din;
  logic        io_sel_q;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_stop;
  logic        tx_overflow;

  io_bridge #(.TX_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .io_din         (io_din),
    .io_sel_q       (io_sel_q),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  logic [7:0]  q[$];
  logic        m_ovf = 0, m_stop_pend = 0, m_stop = 0, m_full = 0, m_sel = 0;
  logic [7:0]  m_din = 0;
  logic [31:0] m_cnt = 0, m_snap = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_io(input logic [31:0] a);
    return rdy_in && (a[17:16] == 2'b11);
  endfunction

  task automatic model_edge();
    int pre;
    bit pop, io, stopw, push;
    int idx;
    if (!rst_in) begin
      q.delete();
      m_ovf = 0; m_stop_pend = 0; m_stop = 0; m_full = 0; m_sel = 0;
      m_din = 0; m_cnt = 0; m_snap = 0;
    end else begin
      pre   = q.size();
      pop   = (pre != 0) && tx_ready;
      io    = is_io(cpu_a);
      stopw = io && cpu_wr && (cpu_a == 32'h30004);
      push  = stopw || (io && cpu_wr && cpu_a == 32'h30000 && cpu_dout != 8'h00);
      if (m_stop_pend && pre == 0 && !push) m_stop = 1;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (pre == DEPTH && !pop) m_ovf = 1;
        else q.push_back(stopw ? 8'h00 : cpu_dout);
      end
      m_full = (DEPTH - q.size()) <= MARGIN;
      if (stopw) m_stop_pend = 1;
      m_sel = io && !cpu_wr;
      m_din = 8'h00;
      if (m_sel) begin
        if (cpu_a == 32'h30000) m_din = rx_valid ? rx_data : 8'h00;
        else if (cpu_a >= 32'h30004 && cpu_a <= 32'h30007) begin
          if (cpu_a == 32'h30004) m_snap = m_cnt;
          idx = int'(cpu_a - 32'h30004);
          m_din = m_snap[idx*8 +: 8];
        end
      end
      if (rdy_in) m_cnt = m_cnt + 1;
    end
  endtask

  // One clock: check the combinational pop, advance, then check registered outputs.
  task automatic cyc();
    #1;
    chk("rx_pop", rx_pop, rst_in && is_io(cpu_a) && !cpu_wr && cpu_a == 32'h30000 && rx_valid);
    @(posedge clk_in);
    model_edge();
    #1;
    chk("tx_valid", tx_valid, q.size() != 0);
    if (q.size() != 0) chk("tx_data", tx_data, q[0]);
    chk("io_buffer_full", io_buffer_full, m_full);
    chk("program_stop", program_stop, m_stop);
    chk("tx_overflow", tx_overflow, m_ovf);
    chk("io_sel_q", io_sel_q, m_sel);
    if (m_sel) chk("io_din", io_din, m_din);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_dout = d; cpu_wr = 1;
    cyc();
    cpu_a = 0; cpu_dout = 0; cpu_wr = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    cpu_a = a; cpu_wr = 0;
    cyc();
    cpu_a = 0;
  endtask

  logic [31:0] addr_tab [8] = '{32'h30000, 32'h30004, 32'h30005, 32'h30006,
                                32'h30007, 32'h30008, 32'h20000, 32'h1003_0000};

  initial begin
    rst_in = 0; rdy_in = 1; cpu_a = 0; cpu_dout = 0; cpu_wr = 0;
    tx_ready = 1; rx_data = 0; rx_valid = 0;
    idle(3);
    rst_in = 1;

    // Counter snapshot after 100 cycles
    idle(100);
    rd(32'h30004);
    chk("cnt_after_100", (io_din >= 8'h63 && io_din <= 8'h65), 1);
    rd(32'h30005); rd(32'h30006); rd(32'h30007);

    // Single byte passes straight through; zero byte is ignored
    wr(32'h30000, 8'h41);
    chk("tx_A", tx_data, 8'h41);
    idle(2);
    wr(32'h30000, 8'h00);
    idle(2);

    // Fill with the UART stalled: full after 6, overflow on the 9th, then drain in order
    tx_ready = 0;
    for (int i = 0; i < 9; i++) begin
      wr(32'h30000, 8'h10 + 8'(i));
      if (i == 4) chk("full_after5", io_buffer_full, 0);
      if (i == 5) chk("full_after6", io_buffer_full, 1);
    end
    chk("overflow_after9", tx_overflow, 1);
    tx_ready = 1;
    idle(10);

    // Accesses are frozen while rdy_in is low
    rdy_in = 0;
    wr(32'h30000, 8'h55);
    rd(32'h30004);
    rdy_in = 1;
    rd(32'h30005);

    // RX reads and unmapped addresses
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'($urandom % 2);
      rx_data  = 8'($urandom);
      rd(32'h30000);
    end
    rx_valid = 0;
    rd(32'h30008);
    rd(32'h20000);

    // Program stop only after 'x' and 0x00 have both left
    rst_in = 0; idle(2); rst_in = 1;
    tx_ready = 0;
    wr(32'h30000, 8'h78);
    wr(32'h30004, 8'h00);
    idle(5);
    chk("stop_while_stalled", program_stop, 0);
    tx_ready = 1;
    idle(4);
    chk("stop_after_drain", program_stop, 1);

    // Reset in the middle of a drain discards everything and clears the flags
    rst_in = 0; idle(1); rst_in = 1;
    tx_ready = 0;
    for (int i = 0; i < 9; i++) wr(32'h30000, 8'h60 + 8'(i));
    wr(32'h30004, 8'h00);
    tx_ready = 1;
    idle(3);
    rst_in = 0;
    cyc();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_overflow", tx_overflow, 0);
    chk("rst_stop", program_stop, 0);
    rst_in = 1;
    idle(5);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst_in   = ($urandom % 200) != 0;
      rdy_in   = ($urandom % 8) != 0;
      tx_ready = 1'($urandom % 2);
      rx_valid = 1'($urandom % 2);
      rx_data  = 8'($urandom);
      cpu_a    = addr_tab[$urandom % 8];
      cpu_wr   = 1'($urandom % 2);
      cpu_dout = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      cyc();
    end
    rst_in = 1; rdy_in = 1; cpu_wr = 0; cpu_a = 0; tx_ready = 1;
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
